// File: rtl/scoreboard_mp_if.sv
// Scoreboard bus interface.
// Groups the issue, operand lookup, write-back, commit and occupancy signals
// of scoreboard_mp. The slave modport is the scoreboard itself. The master
// modport is whatever drives it (the issue/commit stages or a testbench).
//   issue_*   : allocation request/grant and the fields of the new entry
//   rs*_      : operand lookup addresses and busy/forwarding answers
//   wb_*      : NR_WB_PORTS packed write-back ports, addressed by trans ID
//   commit_*  : in-order retirement handshake and head-entry fields
//   count_o   : number of occupied entries
interface scoreboard_mp_if #(
  parameter int NR_ENTRIES  = 8,
  parameter int NR_WB_PORTS = 2,
  parameter int XLEN        = 64
);
  localparam int TID_W = $clog2(NR_ENTRIES);
  localparam int CNT_W = $clog2(NR_ENTRIES + 1);

  logic                         flush_i;

  logic                         issue_valid_i;
  logic                         issue_ready_o;
  logic [XLEN-1:0]              issue_pc_i;
  logic [3:0]                   issue_fu_i;
  logic [7:0]                   issue_op_i;
  logic [4:0]                   issue_rd_i;
  logic [XLEN-1:0]              issue_imm_i;
  logic                         issue_ex_valid_i;
  logic [XLEN-1:0]              issue_ex_cause_i;
  logic [TID_W-1:0]             issue_trans_id_o;

  logic [4:0]                   rs1_i;
  logic [4:0]                   rs2_i;
  logic                         rs1_busy_o;
  logic                         rs2_busy_o;
  logic                         rs1_fwd_valid_o;
  logic                         rs2_fwd_valid_o;
  logic [XLEN-1:0]              rs1_fwd_o;
  logic [XLEN-1:0]              rs2_fwd_o;

  logic [NR_WB_PORTS-1:0]       wb_valid_i;
  logic [NR_WB_PORTS*TID_W-1:0] wb_trans_id_i;
  logic [NR_WB_PORTS*XLEN-1:0]  wb_result_i;
  logic [NR_WB_PORTS-1:0]       wb_ex_valid_i;
  logic [NR_WB_PORTS*XLEN-1:0]  wb_ex_cause_i;

  logic                         commit_valid_o;
  logic                         commit_ack_i;
  logic [TID_W-1:0]             commit_trans_id_o;
  logic [XLEN-1:0]              commit_pc_o;
  logic [3:0]                   commit_fu_o;
  logic [7:0]                   commit_op_o;
  logic [4:0]                   commit_rd_o;
  logic [XLEN-1:0]              commit_result_o;
  logic                         commit_ex_valid_o;
  logic [XLEN-1:0]              commit_ex_cause_o;

  logic [CNT_W-1:0]             count_o;

  modport slave (
    input  flush_i,
    input  issue_valid_i, issue_pc_i, issue_fu_i, issue_op_i, issue_rd_i,
           issue_imm_i, issue_ex_valid_i, issue_ex_cause_i,
    output issue_ready_o, issue_trans_id_o,
    input  rs1_i, rs2_i,
    output rs1_busy_o, rs2_busy_o, rs1_fwd_valid_o, rs2_fwd_valid_o,
           rs1_fwd_o, rs2_fwd_o,
    input  wb_valid_i, wb_trans_id_i, wb_result_i, wb_ex_valid_i, wb_ex_cause_i,
    output commit_valid_o, commit_trans_id_o, commit_pc_o, commit_fu_o,
           commit_op_o, commit_rd_o, commit_result_o, commit_ex_valid_o,
           commit_ex_cause_o,
    input  commit_ack_i,
    output count_o
  );

  modport master (
    output flush_i,
    output issue_valid_i, issue_pc_i, issue_fu_i, issue_op_i, issue_rd_i,
           issue_imm_i, issue_ex_valid_i, issue_ex_cause_i,
    input  issue_ready_o, issue_trans_id_o,
    output rs1_i, rs2_i,
    input  rs1_busy_o, rs2_busy_o, rs1_fwd_valid_o, rs2_fwd_valid_o,
           rs1_fwd_o, rs2_fwd_o,
    output wb_valid_i, wb_trans_id_i, wb_result_i, wb_ex_valid_i, wb_ex_cause_i,
    input  commit_valid_o, commit_trans_id_o, commit_pc_o, commit_fu_o,
           commit_op_o, commit_rd_o, commit_result_o, commit_ex_valid_o,
           commit_ex_cause_o,
    output commit_ack_i,
    input  count_o
  );
endinterface

// File: rtl/scoreboard_mp.sv
// Parametrised issue/execute/commit scoreboard.
// This is a circular buffer of NR_ENTRIES slots.
//   - Issue allocates the slot at issue_ptr.
//   - Functional units write results back by transaction ID on NR_WB_PORTS
//     ports.
//   - The commit stage retires the head (commit_ptr) in program order
//     through a valid/ack handshake.
//   - Operand lookup returns busy/forwarding information from the youngest
//     allocated producer of a register.
//   - flush_i empties the buffer at the next edge.
// Ports:
//   clk_i  clock
//   rst_i  asynchronous active-high reset
//   sb     scoreboard_mp_if.slave: issue, lookup, write-back, commit, count
module scoreboard_mp #(
  parameter int NR_ENTRIES  = 8,
  parameter int NR_WB_PORTS = 2,
  parameter int XLEN        = 64
) (
  input  logic            clk_i,
  input  logic            rst_i,
  scoreboard_mp_if.slave  sb
);
  localparam int TID_W = $clog2(NR_ENTRIES);
  localparam int CNT_W = $clog2(NR_ENTRIES + 1);

  // Control state (reset)
  logic [TID_W-1:0]      issue_ptr;
  logic [TID_W-1:0]      commit_ptr;
  logic [CNT_W-1:0]      count;
  logic [NR_ENTRIES-1:0] alloc;
  logic [NR_ENTRIES-1:0] done;

  // Entry payload (no reset; only meaningful while alloc is set)
  logic [XLEN-1:0]       pc_mem       [NR_ENTRIES];
  logic [3:0]            fu_mem       [NR_ENTRIES];
  logic [7:0]            op_mem       [NR_ENTRIES];
  logic [4:0]            rd_mem       [NR_ENTRIES];
  logic [XLEN-1:0]       result_mem   [NR_ENTRIES];
  logic [XLEN-1:0]       ex_cause_mem [NR_ENTRIES];
  logic [NR_ENTRIES-1:0] ex_valid;

  logic issue_ready;
  logic issue_fire;
  logic commit_valid;
  logic commit_fire;

  assign issue_ready  = (count != CNT_W'(NR_ENTRIES)) & ~sb.flush_i;
  assign issue_fire   = sb.issue_valid_i & issue_ready;
  assign commit_valid = alloc[commit_ptr] & done[commit_ptr] & ~sb.flush_i;
  assign commit_fire  = commit_valid & sb.commit_ack_i;

  // Write-back decode.
  // A port only takes effect on an allocated entry that does not already
  // carry an exception, so the first recorded cause is never overwritten.
  logic [TID_W-1:0]       wb_id [NR_WB_PORTS];
  logic [NR_WB_PORTS-1:0] wb_hit;

  genvar gi;
  generate
    for (gi = 0; gi < NR_WB_PORTS; gi++) begin : g_wb
      assign wb_id[gi]  = sb.wb_trans_id_i[gi*TID_W +: TID_W];
      assign wb_hit[gi] = sb.wb_valid_i[gi] & alloc[wb_id[gi]] &
                          ~ex_valid[wb_id[gi]] & ~sb.flush_i;
    end
  endgenerate

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      issue_ptr  <= '0;
      commit_ptr <= '0;
      count      <= '0;
      alloc      <= '0;
      done       <= '0;
    end else if (sb.flush_i) begin
      issue_ptr  <= '0;
      commit_ptr <= '0;
      count      <= '0;
      alloc      <= '0;
      done       <= '0;
    end else begin
      for (int k = 0; k < NR_WB_PORTS; k++) begin
        if (wb_hit[k]) done[wb_id[k]] <= 1'b1;
      end
      // Commit and issue never target the same slot.
      // A full buffer blocks issue, and an empty buffer has no valid head.
      if (commit_fire) begin
        alloc[commit_ptr] <= 1'b0;
        done[commit_ptr]  <= 1'b0;
        commit_ptr        <= commit_ptr + 1'b1;
      end
      if (issue_fire) begin
        alloc[issue_ptr] <= 1'b1;
        done[issue_ptr]  <= sb.issue_ex_valid_i;  // faulted entries are born complete
        issue_ptr        <= issue_ptr + 1'b1;
      end
      case ({issue_fire, commit_fire})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // Payload writes. A higher-index write-back port overrides a lower one
  // that targets the same entry.
  always_ff @(posedge clk_i) begin
    for (int k = 0; k < NR_WB_PORTS; k++) begin
      if (wb_hit[k]) begin
        result_mem[wb_id[k]]   <= sb.wb_result_i[k*XLEN +: XLEN];
        ex_valid[wb_id[k]]     <= sb.wb_ex_valid_i[k];
        ex_cause_mem[wb_id[k]] <= sb.wb_ex_cause_i[k*XLEN +: XLEN];
      end
    end
    if (issue_fire) begin
      pc_mem[issue_ptr]       <= sb.issue_pc_i;
      fu_mem[issue_ptr]       <= sb.issue_fu_i;
      op_mem[issue_ptr]       <= sb.issue_op_i;
      rd_mem[issue_ptr]       <= sb.issue_rd_i;
      result_mem[issue_ptr]   <= sb.issue_imm_i;
      ex_valid[issue_ptr]     <= sb.issue_ex_valid_i;
      ex_cause_mem[issue_ptr] <= sb.issue_ex_cause_i;
    end
  end

  // Operand lookup.
  // age_idx[i] is the i-th oldest slot. Allocated entries are contiguous
  // from the head, so the last match in this order is the youngest producer.
  logic [TID_W-1:0] age_idx [NR_ENTRIES];
  logic [4:0]       rs_addr [2];
  logic [1:0]       lk_busy;
  logic [1:0]       lk_fwd_valid;
  logic [XLEN-1:0]  lk_fwd [2];

  generate
    for (gi = 0; gi < NR_ENTRIES; gi++) begin : g_age
      assign age_idx[gi] = commit_ptr + TID_W'(gi);
    end
  endgenerate

  assign rs_addr[0] = sb.rs1_i;
  assign rs_addr[1] = sb.rs2_i;

  generate
    for (gi = 0; gi < 2; gi++) begin : g_lookup
      logic             hit;
      logic [TID_W-1:0] sel;
      always_comb begin
        hit = 1'b0;
        sel = '0;
        for (int i = 0; i < NR_ENTRIES; i++) begin
          if (alloc[age_idx[i]] && (rd_mem[age_idx[i]] == rs_addr[gi]) &&
              (rs_addr[gi] != 5'd0)) begin
            hit = 1'b1;
            sel = age_idx[i];
          end
        end
      end
      assign lk_busy[gi]      = hit;
      assign lk_fwd_valid[gi] = hit & done[sel] & ~ex_valid[sel];
      assign lk_fwd[gi]       = hit ? result_mem[sel] : '0;
    end
  endgenerate

  assign sb.rs1_busy_o      = lk_busy[0];
  assign sb.rs2_busy_o      = lk_busy[1];
  assign sb.rs1_fwd_valid_o = lk_fwd_valid[0];
  assign sb.rs2_fwd_valid_o = lk_fwd_valid[1];
  assign sb.rs1_fwd_o       = lk_fwd[0];
  assign sb.rs2_fwd_o       = lk_fwd[1];

  // Issue / commit outputs.
  // Head payload is zeroed when there is nothing to commit.
  assign sb.issue_ready_o     = issue_ready;
  assign sb.issue_trans_id_o  = issue_ptr;
  assign sb.commit_valid_o    = commit_valid;
  assign sb.commit_trans_id_o = commit_ptr;
  assign sb.commit_pc_o       = commit_valid ? pc_mem[commit_ptr]       : '0;
  assign sb.commit_fu_o       = commit_valid ? fu_mem[commit_ptr]       : '0;
  assign sb.commit_op_o       = commit_valid ? op_mem[commit_ptr]       : '0;
  assign sb.commit_rd_o       = commit_valid ? rd_mem[commit_ptr]       : '0;
  assign sb.commit_result_o   = commit_valid ? result_mem[commit_ptr]   : '0;
  assign sb.commit_ex_valid_o = commit_valid & ex_valid[commit_ptr];
  assign sb.commit_ex_cause_o = commit_valid ? ex_cause_mem[commit_ptr] : '0;
  assign sb.count_o           = count;
endmodule
